// File: rtl/rom_burst_reader.sv
// rom_burst_reader: parameter-initialised ROM streaming bursts over valid/ready with a 2-entry skid buffer
module rom_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH = 8,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int LEN_W = 4,
  parameter bit BIG_ENDIAN = 1'b0,
  parameter logic [DEPTH*DATA_WIDTH-1:0] INIT_BYTES = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [LEN_W-1:0]      req_len,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy
);
  localparam int NB = DATA_WIDTH / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);
  localparam logic [LEN_W:0] ONE = (LEN_W + 1)'(1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_n;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W:0] rem;
  logic [DATA_WIDTH-1:0] d0, d1, rd;
  logic l0, l1, accept, issue, pop, rd_last;
  logic [1:0] cnt;
  assign req_ready = (state == IDLE) & !reset;
  assign busy = state != IDLE;
  assign out_valid = cnt != 2'd0;
  assign out_data = out_valid ? d0 : '0;
  assign out_last = out_valid & l0;
  assign accept = req_valid & req_ready;
  assign pop = out_valid & out_ready;
  assign rd_last = rem == ONE;
  // ROM word lookup: bytes packed per endianness, out-of-range addresses read as zero
  always_comb begin
    rd = '0;
    for (int b = 0; b < NB; b++)
      if ({1'b0, addr} < DEPTH_X)
        rd[8*(BIG_ENDIAN ? NB-1-b : b) +: 8] = INIT_BYTES[8*(int'(addr)*NB+b) +: 8];
  end
  // Issue a read only when the skid buffer has room for it; sequence IDLE -> RUN -> DRAIN
  always_comb begin
    issue = (state == RUN) & (rem != '0) & (cnt != 2'd2);
    state_n = (state == IDLE) ? (accept ? RUN : IDLE)
            : (state == RUN)  ? ((issue && rd_last) ? DRAIN : RUN)
            : ((pop && l0) ? IDLE : DRAIN);
  end
  // State register, address/count counters, and the skid buffer receiving registered ROM reads
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      addr <= '0;
      rem <= '0;
      cnt <= 2'd0;
      d0 <= '0;
      d1 <= '0;
      l0 <= 1'b0;
      l1 <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        addr <= req_addr;
        rem <= {1'b0, req_len} + ONE;
      end else if (issue) begin
        addr <= (addr >= LAST_ADDR) ? '0 : addr + 1'b1;
        rem <= rem - ONE;
      end
      cnt <= cnt + 2'(issue) - 2'(pop);
      if (pop || cnt == 2'd0) begin
        d0 <= (cnt == 2'd2) ? d1 : rd;
        l0 <= (cnt == 2'd2) ? l1 : rd_last;
      end
      if (issue && cnt == 2'd1 && !pop) begin
        d1 <= rd;
        l1 <= rd_last;
      end
    end
  end
endmodule

// File: tb/tb_rom_burst_reader.sv
// tb_rom_burst_reader: table, hand-written and random bursts checked against a byte-level ROM model
module tb_rom_burst_reader;
  localparam logic [159:0] INIT = 160'h00000020_01FF0D0C_0B0A0908_07060504_03020100;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic req_valid = 1'b0, req_valid_b = 1'b0;
  logic [2:0] req_addr = '0;
  logic [3:0] req_len = '0;
  logic out_ready = 1'b0;
  logic req_ready, out_valid, out_last, busy;
  logic [31:0] out_data;
  logic req_ready_b, out_valid_b, out_last_b, busy_b;
  logic [31:0] out_data_b;
  int checks = 0, failures = 0;
  typedef struct { logic [31:0] d; logic l; } beat_t;
  beat_t q[$];
  typedef struct { logic [2:0] addr; logic [3:0] len; int mode; logic [31:0] first; logic [31:0] lastw; } vec_t;
  logic [7:0] ib [20] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09,
                          8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'hFF, 8'h01, 8'h20, 8'h00, 8'h00, 8'h00};
  bit pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  rom_burst_reader #(.DATA_WIDTH(32), .DEPTH(5), .LEN_W(4), .BIG_ENDIAN(1'b0), .INIT_BYTES(INIT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_len(req_len), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy));
  rom_burst_reader #(.DATA_WIDTH(32), .DEPTH(5), .LEN_W(4), .BIG_ENDIAN(1'b1), .INIT_BYTES(INIT)) dut_b (
    .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b), .req_addr(req_addr),
    .req_len(req_len), .out_valid(out_valid_b), .out_ready(out_ready), .out_data(out_data_b),
    .out_last(out_last_b), .busy(busy_b));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int a, input bit be);
    logic [31:0] w = '0;
    if (a < 5)
      for (int b = 0; b < 4; b++) w[8*(be ? 3-b : b) +: 8] = ib[a*4+b];
    return w;
  endfunction

  task automatic model(input int a, input int len);
    int p = a;
    for (int i = 0; i <= len; i++) begin
      beat_t e;
      e.d = word_of(p, 1'b0);
      e.l = (i == len);
      q.push_back(e);
      p = (p >= 4) ? 0 : p + 1;
    end
  endtask

  task automatic step();
    logic hs, stall, l;
    logic [31:0] d;
    hs = out_valid & out_ready & !reset;
    stall = out_valid & !out_ready & !reset;
    d = out_data;
    l = out_last;
    @(posedge clk);
    #1;
    if (hs) begin
      chk("beat_expected", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        beat_t e = q.pop_front();
        chk("beat_data", d, e.d);
        chk("beat_last", 32'(l), 32'(e.l));
      end
    end
    if (stall) begin
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_data", out_data, d);
      chk("stall_last", 32'(out_last), 32'(l));
    end
  endtask

  task automatic run_burst(input vec_t v);
    int cyc = 0;
    req_addr = v.addr;
    req_len = v.len;
    req_valid = 1'b1;
    out_ready = (v.mode == 0);
    chk("idle_ready", 32'(req_ready), 32'd1);
    model(int'(v.addr), int'(v.len));
    step();
    req_addr = 3'($urandom);
    req_len = 4'($urandom);
    chk("lat_early", 32'(out_valid), 32'd0);
    step();
    chk("latency", 32'(out_valid), 32'd1);
    chk("first_word", out_data, v.first);
    while (q.size() > 0 && cyc < 300) begin
      req_valid = 1'($urandom);
      out_ready = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? pat[cyc % 6] : 1'($urandom);
      chk("busy_ready", 32'(req_ready), 32'd0);
      if (v.mode == 0) chk("bubble", 32'(out_valid), 32'd1);
      if (q.size() == 1 && out_valid && out_ready) begin
        chk("last_word", out_data, v.lastw);
        chk("last_flag", 32'(out_last), 32'd1);
      end
      step();
      cyc++;
    end
    req_valid = 1'b0;
    chk("drained", 32'(q.size()), 32'd0);
    chk("done_ready", 32'(req_ready), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    vec_t tbl [6];
    tbl[0] = '{3'd0, 4'd4, 0, 32'h03020100, 32'h00000020};
    tbl[1] = '{3'd3, 4'd3, 0, 32'h01FF0D0C, 32'h07060504};
    tbl[2] = '{3'd0, 4'd4, 1, 32'h03020100, 32'h00000020};
    tbl[3] = '{3'd6, 4'd1, 0, 32'h00000000, 32'h03020100};
    tbl[4] = '{3'd7, 4'd2, 2, 32'h00000000, 32'h07060504};
    tbl[5] = '{3'd4, 4'd0, 0, 32'h00000020, 32'h00000020};
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_last", 32'(out_last), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);
    for (int i = 0; i < 6; i++) run_burst(tbl[i]);
    req_addr = 3'd0;
    req_len = 4'd0;
    req_valid_b = 1'b1;
    out_ready = 1'b1;
    step();
    req_valid_b = 1'b0;
    step();
    chk("be_valid", 32'(out_valid_b), 32'd1);
    chk("be_data", out_data_b, 32'h00010203);
    chk("be_last", 32'(out_last_b), 32'd1);
    step();
    chk("be_ready", 32'(req_ready_b), 32'd1);
    chk("be_drop", 32'(out_valid_b), 32'd0);
    req_addr = 3'd0;
    req_len = 4'd4;
    req_valid = 1'b1;
    model(0, 4);
    step();
    req_valid = 1'b0;
    step();
    for (int c = 0; c < 20 && q.size() > 3; c++) step();
    chk("pre_rst_beats", 32'(q.size()), 32'd3);
    reset = 1'b1;
    step();
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_last", 32'(out_last), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    q.delete();
    reset = 1'b0;
    #1;
    chk("mid_rst_ready", 32'(req_ready), 32'd1);
    run_burst('{3'd1, 4'd0, 0, 32'h07060504, 32'h07060504});
    for (int i = 0; i < 40; i++) begin
      vec_t v;
      int p;
      v.addr = 3'($urandom_range(0, 7));
      v.len = 4'($urandom_range(0, 15));
      v.mode = int'($urandom_range(0, 2));
      v.first = word_of(int'(v.addr), 1'b0);
      p = int'(v.addr);
      for (int k = 0; k < int'(v.len); k++) p = (p >= 4) ? 0 : p + 1;
      v.lastw = word_of(p, 1'b0);
      run_burst(v);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();
    chk("idle_quiet", 32'(out_valid), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/rom_burst_reader.md
# rom_burst_reader

Parametrised, generator-initialised read-only memory with a burst-read engine. A single request (start address plus beat count) streams consecutive ROM words out on a valid/ready interface, at one beat per cycle, with full backpressure support. Word width, depth, byte order and burst length are set by parameters. The block sits between a sequencer (the request side) and any stream consumer, such as a table-driven config loader or a coefficient feed.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8; NB = DATA_WIDTH/8 bytes per word
- DEPTH, 8, number of words; must be ≥ 2; need not be a power of two
- ADDR_W, $clog2(DEPTH), address width
- LEN_W, 4, burst length field width
- BIG_ENDIAN, 0, byte order used when words are packed from INIT_BYTES
- INIT_BYTES, 0, DEPTH*DATA_WIDTH-bit vector; byte k is INIT_BYTES[8k+:8]
- clk  input  1  clock; all logic is on the rising edge
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  burst request valid
- req_ready  output  1  burst engine idle; can accept a request
- req_addr  input  ADDR_W  start word address
- req_len  input  LEN_W  beats minus one (0 means 1 beat; max 2^LEN_W beats)
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts the beat
- out_data  output  DATA_WIDTH  ROM word
- out_last  output  1  final beat of the burst; qualified by out_valid
- busy  output  1  burst in progress (inverse of req_ready outside reset)

## Operation
- Word packing:
  - word i = bytes i*NB .. i*NB+NB-1.
  - Little-endian (BIG_ENDIAN=0): byte i*NB lands in bits [7:0].
  - Big-endian (BIG_ENDIAN=1): byte i*NB lands in the MSB byte.
- Address range:
  - Addresses ≥ DEPTH read as all-zero; no X is ever driven.
  - Next address = 0 if the current address is ≥ DEPTH-1, else current + 1.
- FSM states:
  - IDLE: req_ready=1. A request handshake (req_valid & req_ready) loads the address counter from req_addr and the remaining count from req_len+1, then moves to RUN.
  - RUN: issues one ROM read per cycle while remaining > 0 and (in-flight reads + buffered beats) < 2. Moves to DRAIN when the final read has issued.
  - DRAIN: waits for the out_last handshake, then returns to IDLE.
- ROM read is registered, with 1-cycle read latency.
- Output has a 2-entry skid buffer, which sustains one beat per cycle when out_ready is held at 1.
- out_last is set on exactly the (req_len+1)-th beat.
- New requests are accepted only in IDLE. req_* inputs are ignored at all other times.

## Timing
- Reset values (registered, applied at any clk edge with reset=1):
  - out_valid=0, out_last=0, out_data=0, busy=0
  - state = IDLE, address counter = 0, remaining count = 0
  - skid buffer and in-flight pipeline flushed
- req_ready = (state==IDLE) & !reset.
- Request latency: if the handshake occurs at edge E0, the first beat is registered at E1. out_valid is high in the cycle after E1, so acceptance to first visible beat is 2 edges.
- Throughput: with out_ready=1 throughout, beats appear on consecutive cycles with no bubbles.
- Stall rule: while out_valid=1 and out_ready=0, out_data and out_last must hold stable, and out_valid must not drop.
- Completion: after the out_last handshake edge, req_ready=1 in the following cycle. Two back-to-back bursts therefore have a minimum gap of 2 idle cycles on the output.
- Reset mid-burst: all in-flight and buffered beats are discarded, with no partial out_last. out_valid=0 in the cycle after the reset edge. req_ready=1 in the first cycle after reset is released.
- Single beat (req_len=0): out_last=1 on that beat.

## Test plan
Configuration for tests 1–3, 5, 6: DATA_WIDTH=32, DEPTH=5, little-endian. INIT_BYTES = 00..0B, 0C, 0D, FF, 01, 20, 00, 00, 00, giving words 03020100, 07060504, 0B0A0908, 01FF0D0C, 00000020.
1. Basic burst, out_ready=1, addr=0, len=4 -> 5 consecutive beats 03020100, 07060504, 0B0A0908, 01FF0D0C, 00000020; first beat 2 edges after accept; out_last on beat 5 only.
2. Wrap, addr=3, len=3 -> 01FF0D0C, 00000020, 03020100, 07060504; out_last on 07060504.
3. Backpressure, addr=0, len=4, out_ready pattern 1,0,0,1,0,1,... -> same 5 words in order, none lost or duplicated; out_data stable during every stall; req_ready low until the last handshake.
4. Big-endian, BIG_ENDIAN=1, addr=0, len=0 -> single beat 00010203 with out_last=1; req_ready=1 two cycles after accept.
5. Out-of-range, addr=6 (with ADDR_W=3), len=1 -> 00000000, then 03020100 (last).
6. Reset mid-burst: addr=0, len=4, assert reset after 2 beats -> out_valid=0 the next cycle; after release, addr=1, len=0 -> only 07060504 (last), with no stale beats.
